// File: rtl/alu_mul_seq.sv
// alu_mul_seq: multi-cycle unsigned 4x4->8 multiplier using shift-and-add,
// borrowing an external 4-bit ALU as its only adder.
//
// Ports:
//   clk        - rising-edge clock
//   reset_n    - asynchronous active-low reset
//   start      - multiply request, sampled only in IDLE
//   a, b       - multiplicand / multiplier, captured on the accepting edge
//   busy       - high while the four add-shift iterations run
//   done       - one-cycle pulse; product valid from this cycle on
//   product    - 8-bit result, held until the next result is written
//   prod_zero  - product == 0
//   alu_A/B    - ALU operand drive
//   alu_op     - ALU operation select drive
//   alu_l      - ALU logic/arith select drive
//   alu_R      - ALU result (combinational from alu_A/alu_B)
//   alu_carry  - ALU carry out
module alu_mul_seq #(
  parameter logic [1:0] OP_ADD  = 2'b00,
  parameter logic       L_ARITH = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] product,
  output logic       prod_zero,
  output logic [3:0] alu_A,
  output logic [3:0] alu_B,
  output logic [1:0] alu_op,
  output logic       alu_l,
  input  logic [3:0] alu_R,
  input  logic       alu_carry
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] m_q, m_d;
  logic [3:0] p_q, p_d;
  logic [3:0] q_q, q_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] product_q, product_d;

  // One add-shift step: the 9-bit sum {carry, R, Q} shifted right by one.
  // The carry lands in P[3], so no partial-sum bit is ever dropped.
  logic [3:0] p_step, q_step;
  assign p_step = {alu_carry, alu_R[3:1]};
  assign q_step = {alu_R[0], q_q[3:1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      m_q       <= 4'h0;
      p_q       <= 4'h0;
      q_q       <= 4'h0;
      cnt_q     <= 2'd0;
      product_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      p_q       <= p_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    p_d       = p_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          m_d     = a;
          q_d     = b;
          p_d     = 4'h0;
          cnt_d   = 2'd0;
        end
      end
      S_RUN: begin
        p_d   = p_step;
        q_d   = q_step;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d   = S_DONE;
          product_d = {p_step, q_step};
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign product   = product_q;
  assign prod_zero = (product_q == 8'h00);

  // ALU is parked at 0+0 outside RUN; in RUN it adds M only when the
  // current multiplier bit is set.
  assign alu_A  = busy ? p_q : 4'h0;
  assign alu_B  = (busy && q_q[0]) ? m_q : 4'h0;
  assign alu_op = OP_ADD;
  assign alu_l  = L_ARITH;

endmodule

// File: tb/tb_alu_mul_seq.sv
module tb_alu_mul_seq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [3:0] a, b;
  logic       busy, done, prod_zero;
  logic [7:0] product;
  logic [3:0] alu_A, alu_B, alu_R;
  logic [1:0] alu_op;
  logic       alu_l, alu_carry;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  alu_mul_seq #(.OP_ADD(2'b00), .L_ARITH(1'b0)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .product   (product),
    .prod_zero (prod_zero),
    .alu_A     (alu_A),
    .alu_B     (alu_B),
    .alu_op    (alu_op),
    .alu_l     (alu_l),
    .alu_R     (alu_R),
    .alu_carry (alu_carry)
  );

  // Reference ALU: add on the arithmetic path with ADD selected, something
  // visibly different otherwise.
  logic [4:0] alu_sum;
  always_comb begin
    alu_sum = 5'd0;
    if (alu_op == 2'b00 && alu_l == 1'b0) alu_sum = {1'b0, alu_A} + {1'b0, alu_B};
    else                                  alu_sum = {1'b0, alu_A ^ alu_B};
  end
  assign alu_R     = alu_sum[3:0];
  assign alu_carry = alu_sum[4];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Start a multiply and follow it cycle by cycle to the return to IDLE.
  task automatic run_mul(input logic [3:0] av, input logic [3:0] bv,
                         input logic [7:0] exp, input string nm);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);                       // edge 0 accepted
    start = 1'b0;
    check({nm, " busy0"}, busy, 1);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      check({nm, " busyk"}, {busy, done}, 2'b10);
    end
    @(negedge clk);                       // after edge 4
    check({nm, " done"}, {busy, done}, 2'b01);
    check({nm, " product"}, product, exp);
    check({nm, " prod_zero"}, prod_zero, (exp == 8'h00));
    @(negedge clk);                       // after edge 5, back in IDLE
    check({nm, " idle"}, {busy, done}, 2'b00);
    check({nm, " held"}, product, exp);
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] prod;
  } vec_t;

  vec_t tbl[6];
  int   d0, first_done, second_done;

  initial begin
    tbl[0] = '{4'd13, 4'd11, 8'h8F};
    tbl[1] = '{4'd15, 4'd15, 8'hE1};
    tbl[2] = '{4'd15, 4'd1,  8'h0F};
    tbl[3] = '{4'd1,  4'd15, 8'h0F};
    tbl[4] = '{4'd0,  4'd9,  8'h00};
    tbl[5] = '{4'd7,  4'd9,  8'h3F};

    reset_n = 1'b0; start = 1'b0; a = 4'h0; b = 4'h0;
    repeat (2) @(negedge clk);
    check("rst product", product, 0);
    check("rst prod_zero", prod_zero, 1);
    check("rst busy/done", {busy, done}, 0);
    check("rst aluAB", {alu_A, alu_B}, 0);
    check("rst aluop/l", {alu_op, alu_l}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle busy/done", {busy, done}, 0);
    check("idle product", product, 0);

    for (int i = 0; i < 6; i++) run_mul(tbl[i].a, tbl[i].b, tbl[i].prod, $sformatf("vec%0d", i));

    // Operand and start changes during RUN and DONE are ignored.
    @(negedge clk);
    a = 4'd13; b = 4'd11; start = 1'b1;
    @(negedge clk);                       // edge 0
    a = 4'd2; b = 4'd3;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      a = a + 4'd1; b = b + 4'd5;
      start = k[0];
    end
    start = 1'b1;
    @(negedge clk);                       // DONE, start high
    check("proto done", done, 1);
    check("proto product", product, 8'h8F);
    @(negedge clk);                       // back in IDLE
    start = 1'b0;
    check("proto idle", {busy, done}, 0);
    @(negedge clk);
    check("proto no restart", busy, 0);

    // start held high: results 6 cycles apart.
    a = 4'd5; b = 4'd6; start = 1'b1;
    first_done = -1; second_done = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) begin
        if (first_done < 0) first_done = k;
        else if (second_done < 0) second_done = k;
        check("held product", product, 8'h1E);
      end
    end
    start = 1'b0;
    check("held saw two", (first_done >= 0 && second_done >= 0), 1);
    check("held spacing", second_done - first_done, 6);
    repeat (8) @(negedge clk);

    // Reset mid-run after edge 2 of 7x9.
    @(negedge clk);
    a = 4'd7; b = 4'd9; start = 1'b1;
    @(negedge clk);                       // edge 0
    start = 1'b0;
    @(posedge clk);                       // edge 1
    @(posedge clk);                       // edge 2
    #2 reset_n = 1'b0;
    d0 = done_cnt;
    #1;
    check("midrst product", product, 0);
    check("midrst prod_zero", prod_zero, 1);
    check("midrst busy/done", {busy, done}, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check("midrst no done", done_cnt - d0, 0);
    run_mul(4'd7, 4'd9, 8'h3F, "post-rst");

    // Exhaustive sweep.
    d0 = done_cnt;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        run_mul(i[3:0], j[3:0], 8'(i * j), $sformatf("sw%0dx%0d", i, j));
    check("sweep done count", done_cnt - d0, 256);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
